// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and parity-mode constants for the UART transmitter.
package uart_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
endpackage

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: word-in handshake plus serial line and status bundle of the UART transmitter.
interface uart_tx_param_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_BITS-1:0]        in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic                        txd;
  logic                        busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  modport master (output in_data, in_valid, input in_ready, txd, busy, fifo_count);
  modport slave  (input in_data, in_valid, output in_ready, txd, busy, fifo_count);
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: power-of-two circular buffer; pushes while full and pops while empty are ignored.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-buffered UART transmitter with configurable baud divisor, width, parity and stop bits.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 279,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input logic           clk,
  input logic           rst,
  uart_tx_param_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  state_e               state_q, state_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, fifo_data;
  logic                 par_q, par_d, txd_q, txd_d;
  logic                 bit_end, frame_end, pop, full, empty;
  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(bus.in_valid), .data_i(bus.in_data), .pop_i(pop),
    .data_o(fifo_data), .full_o(full), .empty_o(empty), .count_o(bus.fifo_count)
  );
  assign bit_end   = clk_cnt_q == CW'(CLKS_PER_BIT - 1);
  assign frame_end = state_q == ST_STOP && bit_end && bit_idx_q == IW'(STOP_BITS - 1);
  assign pop       = !empty && (state_q == ST_IDLE || frame_end);
  // txd follows the registered state, so the line lags the FSM by exactly one cycle
  assign txd_d = state_q == ST_START  ? 1'b0 :
                 state_q == ST_DATA   ? shreg_q[0] :
                 state_q == ST_PARITY ? par_q : 1'b1;
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    clk_cnt_d = (state_q == ST_IDLE || bit_end) ? '0 : clk_cnt_q + CW'(1);
    case (state_q)
      ST_START:  if (bit_end) state_d = ST_DATA;
      ST_DATA:   if (bit_end) begin
        shreg_d   = shreg_q >> 1;
        bit_idx_d = bit_idx_q == IW'(DATA_BITS - 1) ? '0 : bit_idx_q + IW'(1);
        if (bit_idx_q == IW'(DATA_BITS - 1)) state_d = PARITY != PAR_NONE ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP:   if (bit_end) begin
        bit_idx_d = frame_end ? '0 : bit_idx_q + IW'(1);
        if (frame_end) state_d = ST_IDLE;
      end
      default: ;
    endcase
    if (pop) begin
      state_d = ST_START;
      shreg_d = fifo_data;
      par_d   = PARITY == PAR_ODD ? ~^fifo_data : ^fifo_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      txd_q     <= txd_d;
    end
  end
  assign bus.txd      = txd_q;
  assign bus.in_ready = !full;
  assign bus.busy     = state_q != ST_IDLE || !empty;
endmodule
